// File: rtl/fetch_unit.sv
// Instruction fetch stage for one core: drives a 1-cycle synchronous instruction
// memory and feeds the ALU, following its fork, branch, stall and halt requests.
module fetch_unit #(
  parameter bit          BOOT   = 1'b1,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [15:0]       branch_val,
  input  logic [32:0]       fork_cxt,
  output logic [15:0]       ins_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              running
);

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic        start;
    logic [15:0] ptr;
    logic [15:0] pc;
  } fork_cxt_t;

  localparam state_e RST_STATE = BOOT ? ST_RUN : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              data_valid_q, data_valid_d;

  fork_cxt_t         fork_c;
  logic [ADDR_W-1:0] fork_pc_c;
  logic [ADDR_W-1:0] branch_pc_c;
  logic              fork_start_c;
  logic              branch_c;
  logic              squash_c;
  logic              present_c;
  logic              halt_c;
  logic              unused_bits;

  assign fork_c       = fork_cxt;
  assign fork_start_c = fork_c.start;
  assign fork_pc_c    = fork_c.pc[ADDR_W-1:0];
  assign branch_pc_c  = branch_val[ADDR_W-1:0];
  assign branch_c     = (state_q == ST_RUN) && branch_en;

  // Upper branch/fork bits and the fork pointer belong to the ALU, not to fetch.
  assign unused_bits  = ^{branch_val, fork_c.ptr, fork_c.pc};

  // The returning word is stale whenever fetch is redirected this cycle.
  assign squash_c  = fork_start_c || branch_c;
  assign present_c = (state_q == ST_RUN) && data_valid_q && !squash_c;
  assign halt_c    = present_c && !stall && (imem_data[15:12] == OP_HALT);

  assign ins_out = (present_c && !halt_c) ? imem_data : 16'h0000;
  assign pc_out  = out_pc_q;
  assign running = (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      issue_pc_q   <= '0;
      out_pc_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_pc_q   <= issue_pc_d;
      out_pc_q     <= out_pc_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Next-state and fetch address; priority is fork > branch > stall > halt > sequential.
  always_comb begin
    state_d      = state_q;
    issue_pc_d   = issue_pc_q;
    out_pc_d     = out_pc_q;
    data_valid_d = data_valid_q;
    imem_addr    = issue_pc_q;

    if (fork_start_c) begin
      imem_addr    = fork_pc_c;
      out_pc_d     = fork_pc_c;
      issue_pc_d   = fork_pc_c + ADDR_W'(1);
      data_valid_d = 1'b1;
      state_d      = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (branch_en) begin
        imem_addr    = branch_pc_c;
        out_pc_d     = branch_pc_c;
        issue_pc_d   = branch_pc_c + ADDR_W'(1);
        data_valid_d = 1'b1;
      end else if (stall) begin
        imem_addr = out_pc_q;
      end else if (halt_c) begin
        imem_addr = out_pc_q;
        state_d   = ST_HALTED;
      end else begin
        imem_addr    = issue_pc_q;
        out_pc_d     = issue_pc_q;
        issue_pc_d   = issue_pc_q + ADDR_W'(1);
        data_valid_d = 1'b1;
      end
    end
  end

endmodule
